// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - byte-stream driven initiator for the internal register bus (optional status byte: REG_MASTER_STATUS_EN)
module reg_bus_master #(
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                     clk_usb,
    input  logic                     reset_n,
    input  logic [7:0]               cmd_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [7:0]               rsp_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datai,
    input  logic [7:0]               reg_datao,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     busy,
    output logic                     err_len
);

    // Counter/length width: must hold LEN (up to 255) and 2**pBYTECNT_SIZE.
    localparam int CW = (pBYTECNT_SIZE >= 8) ? pBYTECNT_SIZE + 1 : 9;
    localparam logic [CW-1:0] MAX_LEN = CW'(1) << pBYTECNT_SIZE;

`ifdef REG_MASTER_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_LEN,
        S_WRITE,
        S_READ,
        S_DRAIN_WR,
        S_DRAIN_RD,
        S_ST_LOAD,
        S_ST_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               addr_q, addr_d;
    logic [pBYTECNT_SIZE-1:0] bytecnt_q, bytecnt_d;
    logic [7:0]               datai_q, datai_d;
    logic [CW-1:0]            len_q, len_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     is_read_q, is_read_d;
    logic                     err_len_q, err_len_d;
    logic                     reg_write_q, reg_write_d;
    logic [7:0]               rsp_data_q, rsp_data_d;
    logic                     rsp_valid_q, rsp_valid_d;

    logic                     cmd_ready_int;
    logic                     reg_read_int;
    logic                     slot_free;
    logic                     rsp_load;
    logic [7:0]               rsp_load_data;
    logic [CW-1:0]            len_ext;
    logic [CW-1:0]            cnt_inc;
    state_t                   done_state;

    // State and datapath registers; everything clears on async reset.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 8'h00;
            bytecnt_q   <= '0;
            datai_q     <= 8'h00;
            len_q       <= '0;
            cnt_q       <= '0;
            is_read_q   <= 1'b0;
            err_len_q   <= 1'b0;
            reg_write_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bytecnt_q   <= bytecnt_d;
            datai_q     <= datai_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
            err_len_q   <= err_len_d;
            reg_write_q <= reg_write_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next-state, bus strobes and response-register loading.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        bytecnt_d     = bytecnt_q;
        datai_d       = datai_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        is_read_d     = is_read_q;
        err_len_d     = err_len_q;
        reg_write_d   = 1'b0;
        cmd_ready_int = 1'b0;
        reg_read_int  = 1'b0;
        rsp_load      = 1'b0;
        rsp_load_data = 8'h00;
        // A new response byte may be produced only if the register is free this cycle.
        slot_free     = !rsp_valid_q || rsp_ready;
        len_ext       = CW'(cmd_data);
        cnt_inc       = cnt_q + CW'(1);
        done_state    = STATUS_EN ? S_ST_LOAD : S_IDLE;

        case (state_q)
            S_IDLE: begin
                cmd_ready_int = 1'b1;
                if (cmd_valid) begin
                    is_read_d = cmd_data[0];
                    state_d   = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                cmd_ready_int = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_data;
                    state_d = S_GET_LEN;
                end
            end
            S_GET_LEN: begin
                cmd_ready_int = 1'b1;
                if (cmd_valid) begin
                    len_d     = len_ext;
                    cnt_d     = '0;
                    bytecnt_d = '0;
                    if (len_ext == '0) begin
                        err_len_d = 1'b1;
                        state_d   = done_state;
                    end else if (len_ext > MAX_LEN) begin
                        err_len_d = 1'b1;
                        state_d   = is_read_q ? S_DRAIN_RD : S_DRAIN_WR;
                    end else begin
                        err_len_d = 1'b0;
                        state_d   = is_read_q ? S_READ : S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // cnt_q counts accepted bytes; the strobe of the last one is
                // live in the cycle where cnt_q reaches len_q.
                if (cnt_q == len_q) begin
                    state_d = done_state;
                end else begin
                    cmd_ready_int = 1'b1;
                    if (cmd_valid) begin
                        reg_write_d = 1'b1;
                        datai_d     = cmd_data;
                        bytecnt_d   = cnt_q[pBYTECNT_SIZE-1:0];
                        cnt_d       = cnt_inc;
                    end
                end
            end
            S_READ: begin
                if (slot_free) begin
                    reg_read_int  = 1'b1;
                    rsp_load      = 1'b1;
                    rsp_load_data = reg_datao;
                    cnt_d         = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = done_state;
                    end else begin
                        bytecnt_d = bytecnt_q + pBYTECNT_SIZE'(1);
                    end
                end
            end
            S_DRAIN_WR: begin
                cmd_ready_int = 1'b1;
                if (cmd_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = done_state;
                    end
                end
            end
            S_DRAIN_RD: begin
                if (slot_free) begin
                    rsp_load      = 1'b1;
                    rsp_load_data = 8'h00;
                    cnt_d         = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = done_state;
                    end
                end
            end
            S_ST_LOAD: begin
                if (slot_free) begin
                    rsp_load      = 1'b1;
                    rsp_load_data = {4'hA, 2'b00, err_len_q, is_read_q};
                    state_d       = S_ST_WAIT;
                end
            end
            S_ST_WAIT: begin
                // The status byte is the only thing in the register here.
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        if (rsp_load) begin
            rsp_data_d  = rsp_load_data;
            rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Output wiring; cmd_ready is forced low while reset is held.
    always_comb begin
        cmd_ready   = cmd_ready_int & reset_n;
        reg_read    = reg_read_int;
        reg_write   = reg_write_q;
        reg_address = addr_q;
        reg_bytecnt = bytecnt_q;
        reg_datai   = datai_q;
        rsp_data    = rsp_data_q;
        rsp_valid   = rsp_valid_q;
        busy        = (state_q != S_IDLE);
        err_len     = err_len_q;
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed plus randomized check of reg_bus_master against a transaction-level model
module tb_reg_bus_master;
    localparam int P = 7;
    localparam int MAXLEN = 1 << P;

    logic         clk_usb = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   cmd_data = 8'h00;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [7:0]   rsp_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   reg_address;
    logic [P-1:0] reg_bytecnt;
    logic [7:0]   reg_datai;
    logic [7:0]   reg_datao;
    logic         reg_read;
    logic         reg_write;
    logic         busy;
    logic         err_len;

    int n_assert = 0;
    int n_fail = 0;

    logic [7:0]  resp_base = 8'hA0;
    int          rdy_mode = 0;
    int          rdy_phase = 0;
    int          cyc = 0;
    int          wr_first = -1;
    int          wr_last = -1;
    logic [23:0] wr_log[$];
    logic [7:0]  rsp_log[$];
    int          rd_strobes = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    reg_bus_master #(.pBYTECNT_SIZE(P)) dut (
        .clk_usb(clk_usb), .reset_n(reset_n),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai),
        .reg_datao(reg_datao), .reg_read(reg_read), .reg_write(reg_write),
        .busy(busy), .err_len(err_len)
    );

    always #5 clk_usb = ~clk_usb;

    // Responder: read data is base plus byte index, combinational on the strobe.
    assign reg_datao = reg_read ? (resp_base + 8'(reg_bytecnt)) : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response-side backpressure: 0 always ready, 1 pattern 1,0,0, 2 random.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk_usb);
            #1;
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: begin rsp_ready = (rdy_phase % 3 == 0); rdy_phase++; end
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Bus and response monitor, sampled mid-cycle.
    always @(negedge clk_usb) begin
        cyc++;
        if (reset_n) begin
            if (reg_read || reg_write) begin
                check("strobe_exclusive", {31'd0, reg_read & reg_write}, 0);
                check("strobe_in_txn", {31'd0, busy}, 1);
            end
            if (prev_stall) begin
                check("rsp_hold_valid", {31'd0, rsp_valid}, 1);
                check("rsp_hold_data", {24'd0, rsp_data}, {24'd0, prev_data});
            end
            if (reg_write) begin
                wr_log.push_back({reg_address, 1'b0, reg_bytecnt, reg_datai});
                if (wr_first < 0) wr_first = cyc;
                wr_last = cyc;
            end
            if (reg_read) rd_strobes++;
            if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_data);
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge clk_usb);
        while (!cmd_ready && t < 200) begin
            @(negedge clk_usb);
            t++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        @(posedge clk_usb);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_txn(input logic rd, input logic [7:0] addr, input int len,
                           input bit fixed_data, input int gap_max, input string tag);
        logic [7:0]  c;
        logic [7:0]  d;
        logic [23:0] exp_wr[$];
        logic [7:0]  exp_rsp[$];
        int          exp_reads;
        logic        exp_err;
        bit          legal;
        int          t;
        wr_log.delete();
        rsp_log.delete();
        rd_strobes = 0;
        wr_first = -1;
        wr_last = -1;
        legal = (len >= 1) && (len <= MAXLEN);
        exp_err = !legal;
        c = 8'($urandom);
        c[0] = rd;
        send_byte(c);
        send_byte(addr);
        send_byte(8'(len));
        if (!rd) begin
            for (int i = 0; i < len; i++) begin
                d = fixed_data ? 8'(8'h11 * (i + 1)) : 8'($urandom);
                if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk_usb); #1; end
                send_byte(d);
                if (legal) exp_wr.push_back({addr, 8'(i), d});
            end
        end
        exp_reads = (rd && legal) ? len : 0;
        if (rd) begin
            for (int i = 0; i < len; i++) exp_rsp.push_back(legal ? 8'(resp_base + 8'(i)) : 8'h00);
        end
`ifdef REG_MASTER_STATUS_EN
        exp_rsp.push_back({4'hA, 2'b00, exp_err, rd});
`endif
        t = 0;
        while ((busy || rsp_valid) && t < 3000) begin
            @(negedge clk_usb);
            t++;
        end
        if (t >= 3000) check({tag, "_done_timeout"}, 0, 1);
        repeat (2) @(negedge clk_usb);
        @(posedge clk_usb);
        #1;
        check({tag, "_n_writes"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check({tag, "_write_beat"}, {8'd0, wr_log[i]}, {8'd0, exp_wr[i]});
        check({tag, "_n_reads"}, rd_strobes, exp_reads);
        check({tag, "_n_rsp"}, rsp_log.size(), exp_rsp.size());
        for (int i = 0; i < exp_rsp.size() && i < rsp_log.size(); i++)
            check({tag, "_rsp_byte"}, {24'd0, rsp_log[i]}, {24'd0, exp_rsp[i]});
        check({tag, "_err_len"}, {31'd0, err_len}, {31'd0, exp_err});
        check({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_err_len"}, {31'd0, err_len}, 0);
        check({tag, "_strobes"}, {30'd0, reg_read, reg_write}, 0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 0);
        check({tag, "_rsp_data"}, {24'd0, rsp_data}, 0);
        check({tag, "_bus"}, {1'b0, reg_address, reg_bytecnt, reg_datai}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int len;
        // Reset values
        repeat (3) @(negedge clk_usb);
        check_reset_outputs("reset");
        @(posedge clk_usb);
        #1;
        reset_n = 1'b1;
        @(negedge clk_usb);
        check("post_reset_cmd_ready", {31'd0, cmd_ready}, 1);
        @(posedge clk_usb);
        #1;

        // Directed write, back-to-back, data 11 22 33 44
        rdy_mode = 0;
        run_txn(1'b0, 8'h1C, 4, 1'b1, 0, "wr4");
        check("wr4_back_to_back", wr_last - wr_first, 3);

        // Directed read with 1,0,0 backpressure
        resp_base = 8'hA0;
        rdy_mode = 1;
        rdy_phase = 0;
        run_txn(1'b1, 8'h04, 6, 1'b0, 0, "rd6_bp");

        // LEN 0 then a legal read clears err_len
        rdy_mode = 0;
        run_txn(1'b0, 8'h10, 0, 1'b0, 0, "len0");
        resp_base = 8'h30;
        run_txn(1'b1, 8'h20, 3, 1'b0, 0, "rd_after_len0");

        // Oversized lengths
        run_txn(1'b0, 8'h40, 200, 1'b0, 0, "wr200");
        rdy_mode = 2;
        run_txn(1'b1, 8'h41, 200, 1'b0, 0, "rd200");

        // Boundaries: max legal length, first illegal length
        rdy_mode = 0;
        resp_base = 8'h05;
        run_txn(1'b1, 8'h7F, MAXLEN, 1'b0, 0, "rd_max");
        run_txn(1'b0, 8'h80, MAXLEN, 1'b0, 0, "wr_max");
        run_txn(1'b0, 8'h81, MAXLEN + 1, 1'b0, 0, "wr_max_plus1");

        // Randomized transactions
        for (int k = 0; k < 12; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = $urandom_range(MAXLEN + 1, 255);
            else len = $urandom_range(1, 40);
            rdy_mode = $urandom_range(0, 2);
            resp_base = 8'($urandom);
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), len, 1'b0, 3, "rand");
        end

        // Reset in the middle of a 4-byte write after two bytes
        rdy_mode = 0;
        wr_log.delete();
        send_byte(8'h00);
        send_byte(8'h33);
        send_byte(8'h04);
        send_byte(8'hD1);
        send_byte(8'hD2);
        @(posedge clk_usb);
        #1;
        reset_n = 1'b0;
        @(negedge clk_usb);
        check_reset_outputs("midrst");
        check("midrst_n_writes", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            check("midrst_beat0", {8'd0, wr_log[0]}, {8'd0, 8'h33, 8'h00, 8'hD1});
            check("midrst_beat1", {8'd0, wr_log[1]}, {8'd0, 8'h33, 8'h01, 8'hD2});
        end
        @(posedge clk_usb);
        #1;
        reset_n = 1'b1;
        @(negedge clk_usb);
        check("midrst_release_idle", {31'd0, busy}, 0);
        check("midrst_release_ready", {31'd0, cmd_ready}, 1);
        @(posedge clk_usb);
        #1;
        resp_base = 8'h60;
        run_txn(1'b1, 8'h0A, 2, 1'b0, 0, "after_rst_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator side of the internal byte-wide register bus (`reg_address`/`reg_bytecnt`/`reg_read`/`reg_write`/data) served by the register-file responders.
- Consumes a USB-side command byte stream. Issues one bus cycle per data byte with an incrementing byte count.
- Read-back bytes go out on a response stream with valid/ready backpressure.
- Sits between the USB FIFO interface and all register-file responders.

Parameters:
- pBYTECNT_SIZE, 7, width of `reg_bytecnt`; max transaction length is 2**pBYTECNT_SIZE bytes.

Ports:
- clk_usb  input  1  single clock for the block.
- reset_n  input  1  reset; asynchronous, active-low.
- cmd_data  input  8  command stream byte.
- cmd_valid  input  1  `cmd_data` valid.
- cmd_ready  output  1  block accepts `cmd_data` this cycle.
- rsp_data  output  8  response stream byte.
- rsp_valid  output  1  `rsp_data` valid.
- rsp_ready  input  1  downstream accepts `rsp_data`.
- reg_address  output  8  register address.
- reg_bytecnt  output  pBYTECNT_SIZE  byte index within the register.
- reg_datai  output  8  write data (bus net name; responder input).
- reg_datao  input  8  read data from responders; combinational from `reg_read`/addr/bytecnt.
- reg_read  output  1  read strobe.
- reg_write  output  1  write strobe.
- busy  output  1  transaction in progress (state != IDLE).
- err_len  output  1  sticky; set on illegal length, cleared by next valid header.

Behaviour:
- Reset (`reset_n` low, async): state=IDLE. `reg_read`, `reg_write`, `rsp_valid`, `busy`, `err_len` = 0. `reg_address`=0, `reg_bytecnt`=0, `reg_datai`=0, `rsp_data`=0. `cmd_ready`=0 while reset is asserted.
- Transaction format: byte0 CMD (bit0: 1=read, 0=write; bits7:1 ignored), byte1 ADDR, byte2 LEN (byte count, 1..2**pBYTECNT_SIZE), then LEN data bytes for writes only.
- States: IDLE -> GET_ADDR -> GET_LEN -> (WRITE | READ | DRAIN) -> IDLE.
- IDLE / GET_ADDR / GET_LEN:
  - `cmd_ready`=1; each handshake advances one state.
  - ADDR is latched into `reg_address` and held constant until return to IDLE.
- LEN=0:
  - Set `err_len`; no bus cycles; return to IDLE.
- LEN > 2**pBYTECNT_SIZE:
  - Set `err_len`.
  - Write: go to DRAIN, consume LEN bytes, issue no strobes.
  - Read: go to DRAIN-read, emit LEN bytes of 0x00, issue no strobes.
- Legal LEN: clear `err_len`; byte counter = 0.
- WRITE:
  - `cmd_ready`=1.
  - On each cmd handshake, the next cycle has `reg_write`=1 for exactly one cycle, with `reg_datai`=byte and `reg_bytecnt`=counter; then the counter increments.
  - Back-to-back bytes give back-to-back `reg_write` pulses.
  - After the LEN-th strobe, return to IDLE.
- READ:
  - `cmd_ready`=0.
  - Pulse `reg_read` for one cycle with `reg_bytecnt`=counter, only when the response register is empty or is being consumed that cycle.
  - `reg_datao` is captured at the edge ending the `reg_read` cycle, so `rsp_valid` rises the next cycle (latency 1).
  - The counter increments per strobe.
  - Full rate (one byte per cycle) when `rsp_ready` is held high.
  - While `rsp_ready` is low: `rsp_data`/`rsp_valid` are held stable and no further `reg_read` is issued.
  - Return to IDLE once the LEN-th byte is captured. A pending response may still drain in IDLE, and `cmd_ready` is independent of it.
- Strobes:
  - `reg_read` and `reg_write` are never both high.
  - `reg_address`/`reg_bytecnt`/`reg_datai` are stable during any strobe.
  - No strobe occurs outside READ/WRITE.
- `reg_bytecnt` has width pBYTECNT_SIZE. The counter never wraps within a legal transaction; the max index is 2**pBYTECNT_SIZE-1.
- Reset mid-transaction: immediate abort. Partial writes already strobed stay applied, and the remaining bytes of the aborted stream are not consumed.
- When `cmd_valid` is low, the state holds and no strobe is issued.

Optional Feature:
- Macro: REG_MASTER_STATUS_EN.
- Defined:
  - Every transaction, including errored ones, ends with one extra response byte {4'hA, 2'b00, err_len, cmd_bit0}.
  - The byte is emitted after the final data byte (read) or the final strobe/drain (write).
  - The return to IDLE waits until this byte is accepted.
- Undefined: no status byte; writes produce no response traffic.

Test Plan:
- Write: CMD 0x00, ADDR 0x1C, LEN 4, data 11 22 33 44 with `cmd_valid` continuous -> four consecutive `reg_write` pulses, bytecnt 0..3, `reg_datai` 11,22,33,44, `reg_address`=0x1C throughout; no `reg_read`.
- Read with backpressure: CMD 0x01, ADDR 0x04, LEN 6, responder returns 0xA0+bytecnt, `rsp_ready` toggled 1,0,0,1,... -> `rsp_data` A0..A5 in order, each held while `rsp_ready`=0, exactly 6 `reg_read` pulses.
- LEN 0: CMD 0x00, ADDR 0x10, LEN 0 -> `err_len`=1, no strobes, next header byte accepted. A following legal read clears `err_len`.
- LEN 200 write (pBYTECNT_SIZE=7) -> `err_len`=1, 200 data bytes consumed, zero `reg_write`. LEN 200 read -> 200 bytes of 0x00, zero `reg_read`.
- Reset mid-write: assert `reset_n` low after 2 of 4 write bytes -> exactly 2 strobes observed, all outputs at reset values while asserted, IDLE after release.
- REG_MASTER_STATUS_EN defined: read LEN 2 -> data, data, then 0xA1. Errored LEN 0 write -> single 0xA2.
